alu_mdu: RTL and testbench



---
 rtl/alu_mdu.sv | 177 +++++++++++++++++
 tb/tb_alu_mdu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a
// sign-fixup state. Define ALU_MDU_TRACE_EN to get a one-line $strobe trace
// on every completion (simulation only).
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_in_a,
    input  logic [XLEN-1:0] alu_in_b,
    input  logic [3:0]      alu_in_contr,
    input  logic            mdu_in_valid,
    output logic            mdu_in_ready,
    output logic            mdu_out_busy,
    output logic            mdu_out_done,
    output logic [XLEN-1:0] alu_out_rl,
    output logic [XLEN-1:0] alu_out_rh,
    output logic            mdu_out_dz
);
    localparam logic [3:0] OP_MULT  = 4'h8;
    localparam logic [3:0] OP_MULTU = 4'h9;
    localparam logic [3:0] OP_DIV   = 4'hA;
    localparam logic [3:0] OP_DIVU  = 4'hB;
    localparam logic [3:0] OP_MTHI  = 4'hC;
    localparam logic [3:0] OP_MTLO  = 4'hD;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t            state, state_nx;
    logic [4:0]        cnt;
    logic [2*XLEN-1:0] acc;      // {partial/remainder, multiplier/quotient}
    logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
    logic              div_q;    // in-flight op is a divide
    logic              neg_p;    // negate product / quotient at fixup
    logic              neg_rem;  // negate remainder at fixup
    logic [XLEN-1:0]   hi, lo;
    logic              dz, done;

    logic              accept, is_md, op_div, op_sgn, b_zero;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    assign mdu_out_busy = (state != S_IDLE);
    assign mdu_in_ready = !mdu_out_busy;
    assign mdu_out_done = done;
    assign alu_out_rl   = lo;
    assign alu_out_rh   = hi;
    assign mdu_out_dz   = dz;

    // Request decode and operand magnitudes for signed ops
    always_comb begin
        accept = mdu_in_valid && mdu_in_ready;
        is_md  = (alu_in_contr == OP_MULT) || (alu_in_contr == OP_MULTU) ||
                 (alu_in_contr == OP_DIV)  || (alu_in_contr == OP_DIVU);
        op_div = alu_in_contr[1];
        op_sgn = !alu_in_contr[0];
        b_zero = (alu_in_b == '0);
        a_mag  = (op_sgn && alu_in_a[XLEN-1]) ? -alu_in_a : alu_in_a;
        b_mag  = (op_sgn && alu_in_b[XLEN-1]) ? -alu_in_b : alu_in_b;
    end

    // One iteration step for each algorithm and the sign-corrected results
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        // Shifted remainder never exceeds 2*divisor-1, so XLEN+1 bits suffice
        div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
        prod      = neg_p   ? -acc : acc;
        quo       = neg_p   ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem       = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; divide by zero skips straight to fixup
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept && is_md) state_nx = (op_div && b_zero) ? S_FIX : S_ITER;
            S_ITER: if (cnt == 5'd31) state_nx = S_FIX;
            S_FIX:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO write and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            div_q   <= 1'b0;
            neg_p   <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            dz      <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    if (is_md) begin
                        cnt     <= '0;
                        div_q   <= op_div;
                        neg_p   <= op_sgn && (alu_in_a[XLEN-1] ^ alu_in_b[XLEN-1]);
                        neg_rem <= op_sgn && alu_in_a[XLEN-1];
                        if (op_div) begin
                            acc  <= {{XLEN{1'b0}}, a_mag};
                            opnd <= b_mag;
                            dz   <= b_zero;
                        end else begin
                            acc  <= {{XLEN{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end
                    end else if (alu_in_contr == OP_MTHI) begin
                        hi   <= alu_in_a;
                        done <= 1'b1;
                    end else if (alu_in_contr == OP_MTLO) begin
                        lo   <= alu_in_a;
                        done <= 1'b1;
                    end
                end
                S_ITER: begin
                    cnt <= cnt + 5'd1;
                    if (div_q) begin
                        if (!div_trial[XLEN]) acc <= {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        else                  acc <= {acc[2*XLEN-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (!div_q) begin
                        hi <= prod[2*XLEN-1:XLEN];
                        lo <= prod[XLEN-1:0];
                    end else if (!dz) begin
                        hi <= rem;
                        lo <= quo;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_MDU_TRACE_EN
    logic [3:0]      tr_op;
    logic [XLEN-1:0] tr_a, tr_b;

    // Keep the accepted request for the completion trace
    always_ff @(posedge clk) begin
        if (accept) begin
            tr_op <= alu_in_contr;
            tr_a  <= alu_in_a;
            tr_b  <= alu_in_b;
        end
    end

    // Print one line per completion
    always @(negedge clk) begin
        if (done)
            $strobe("%0t alu_mdu op=%h a=%h b=%h hi=%h lo=%h dz=%h",
                     $time, tr_op, tr_a, tr_b, hi, lo, dz);
    end
`else
    // Trace disabled: no simulation output is compiled in.
`endif

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: vector table plus hand-written sequences
// for back-to-back, busy-ignore and mid-operation reset. Expected results
// are queued at issue and compared by a monitor when done pulses.
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_in_a, alu_in_b;
    logic [3:0]  alu_in_contr;
    logic        mdu_in_valid;
    logic        mdu_in_ready, mdu_out_busy, mdu_out_done, mdu_out_dz;
    logic [31:0] alu_out_rl, alu_out_rh;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_in_contr(alu_in_contr),
        .mdu_in_valid(mdu_in_valid), .mdu_in_ready(mdu_in_ready),
        .mdu_out_busy(mdu_out_busy), .mdu_out_done(mdu_out_done),
        .alu_out_rl(alu_out_rl), .alu_out_rh(alu_out_rh), .mdu_out_dz(mdu_out_dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        has_done;
        logic [31:0] hi, lo;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        logic        dz;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued result
    always @(negedge clk) begin
        if (mdu_out_done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk($sformatf("hi[%0d]", mon_e.id), alu_out_rh, mon_e.hi);
                chk($sformatf("lo[%0d]", mon_e.id), alu_out_rl, mon_e.lo);
                chk($sformatf("dz[%0d]", mon_e.id), {31'd0, mdu_out_dz}, {31'd0, mon_e.dz});
                chk($sformatf("latency[%0d]", mon_e.id), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    // Drive one request at the current (negedge) time; accepted at next posedge
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] hi, input logic [31:0] lo,
                         input logic dz, input int lat, input int id);
        exp_t e;
        chk($sformatf("ready_at_issue[%0d]", id), {31'd0, mdu_in_ready}, 32'd1);
        alu_in_contr = op;
        alu_in_a     = a;
        alu_in_b     = b;
        mdu_in_valid = 1'b1;
        if (push) begin
            e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat; e.acc = cyc + 1; e.id = id;
            sbq.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        mdu_in_valid = 1'b0;
        alu_in_a     = $urandom;
        alu_in_b     = $urandom;
        alu_in_contr = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending expected=0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // op, a, b, has_done, hi, lo, dz, latency
        vt[0]  = '{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vt[1]  = '{4'h8, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vt[2]  = '{4'hA, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vt[3]  = '{4'hB, 32'h00000007, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1};
        vt[4]  = '{4'h8, 32'h00000002, 32'h00000003, 1'b1, 32'h00000000, 32'h00000006, 1'b1, 33};
        vt[5]  = '{4'hA, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 1'b0, 33};
        vt[6]  = '{4'h8, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 1'b0, 33};
        vt[7]  = '{4'hA, 32'h00000007, 32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vt[8]  = '{4'hB, 32'hFFFFFFFF, 32'h00000010, 1'b1, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
        vt[9]  = '{4'h9, 32'h12345678, 32'h00000010, 1'b1, 32'h00000001, 32'h23456780, 1'b0, 33};
        vt[10] = '{4'hA, 32'h00000064, 32'h00000007, 1'b1, 32'h00000002, 32'h0000000E, 1'b0, 33};
        vt[11] = '{4'hC, 32'hDEADBEEF, 32'h00000000, 1'b1, 32'hDEADBEEF, 32'h0000000E, 1'b0, 0};
        vt[12] = '{4'hD, 32'h00000055, 32'h11111111, 1'b1, 32'hDEADBEEF, 32'h00000055, 1'b0, 0};
        vt[13] = '{4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hDEADBEEF, 32'h00000055, 1'b0, 0};

        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("reset_hi", alu_out_rh, 32'h0);
        chk("reset_lo", alu_out_rl, 32'h0);
        chk("reset_ready", {31'd0, mdu_in_ready}, 32'd1);
        chk("reset_busy", {31'd0, mdu_out_busy}, 32'd0);
        chk("reset_done", {31'd0, mdu_out_done}, 32'd0);
        chk("reset_dz", {31'd0, mdu_out_dz}, 32'd0);
        rst = 1'b0;

        // Table-driven vectors, results chained through HI/LO/dz
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vt[i].op, vt[i].a, vt[i].b, vt[i].has_done, vt[i].hi, vt[i].lo,
                  vt[i].dz, vt[i].lat, i);
            @(negedge clk);
            idle_inputs();
            if (vt[i].has_done) begin
                wait_drain();
            end else begin
                repeat (5) @(negedge clk);
                chk($sformatf("noop_busy[%0d]", i), {31'd0, mdu_out_busy}, 32'd0);
                chk($sformatf("noop_hi[%0d]", i), alu_out_rh, vt[i].hi);
                chk($sformatf("noop_lo[%0d]", i), alu_out_rl, vt[i].lo);
            end
        end

        // MTHI then MTLO on consecutive cycles: one done pulse each
        @(negedge clk);
        drive(4'hC, 32'h12345678, 32'h0, 1'b1, 32'h12345678, 32'h00000055, 1'b0, 0, 100);
        @(negedge clk);
        drive(4'hD, 32'h9ABCDEF0, 32'h0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 0, 101);
        @(negedge clk);
        idle_inputs();
        wait_drain();
        @(negedge clk);
        chk("b2b_done_low", {31'd0, mdu_out_done}, 32'd0);

        // Request during busy is ignored; next op accepted in the done cycle
        drive(4'h9, 32'h00000003, 32'h00000005, 1'b1, 32'h0, 32'h0000000F, 1'b0, 33, 102);
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);
        chk("busy_ready", {31'd0, mdu_in_ready}, 32'd0);
        chk("busy_busy", {31'd0, mdu_out_busy}, 32'd1);
        alu_in_contr = 4'hC;
        alu_in_a     = 32'h00000BAD;
        mdu_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        idle_inputs();
        n = 0;
        while (mdu_out_done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, mdu_out_done}, 32'd1);
        drive(4'hD, 32'h00000077, 32'h0, 1'b1, 32'h0, 32'h00000077, 1'b0, 0, 103);
        @(negedge clk);
        idle_inputs();
        wait_drain();

        // Divide by zero sets dz, then reset in the middle of a DIVU
        @(negedge clk);
        drive(4'hB, 32'h00000001, 32'h0, 1'b1, 32'h0, 32'h00000077, 1'b1, 1, 104);
        @(negedge clk);
        idle_inputs();
        wait_drain();
        @(negedge clk);
        drive(4'hB, 32'hFFFFFFFF, 32'h00000003, 1'b0, 32'h0, 32'h0, 1'b0, 0, 105);
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_hi", alu_out_rh, 32'h0);
        chk("midreset_lo", alu_out_rl, 32'h0);
        chk("midreset_ready", {31'd0, mdu_in_ready}, 32'd1);
        chk("midreset_busy", {31'd0, mdu_out_busy}, 32'd0);
        chk("midreset_done", {31'd0, mdu_out_done}, 32'd0);
        chk("midreset_dz", {31'd0, mdu_out_dz}, 32'd0);
        rst = 1'b0;
        drive(4'h9, 32'h00000006, 32'h00000007, 1'b1, 32'h0, 32'h0000002A, 1'b0, 33, 106);
        @(negedge clk);
        idle_inputs();
        wait_drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
